phase_timer: RTL

Parametrised multi-phase countdown timer for the traffic-light controller, replacing the fixed two-duration green/yellow timer. Holds one programmable duration per phase, supplied as a packed vector. Runs one phase per start request, or free-runs through all phases in order when auto mode is set. Supports pause (pedestrian hold), abort, per-phase sticky expiry flags and a single-cycle done pulse, and sits between the light FSM and the clock domain.

---
 rtl/phase_timer.sv | 98 +++++++++
 1 files changed

// File: rtl/phase_timer.sv
// phase_timer: multi-phase programmable countdown timer for the traffic-light controller.
// It supports one-shot or auto-cycling phases, pause, abort, sticky expiry flags and done/err pulses.
module phase_timer #(
  parameter int NUM_PHASES = 3,
  parameter int CNT_W = 27,
  parameter bit AUTO_CYCLE = 1'b0,
  localparam int PHASE_W = $clog2(NUM_PHASES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [PHASE_W-1:0]          phase_sel,
  input  logic [NUM_PHASES*CNT_W-1:0] dur_vec,
  input  logic                        pause,
  input  logic                        abort,
  input  logic                        clr_flags,
  output logic                        busy,
  output logic                        done,
  output logic [PHASE_W-1:0]          cur_phase,
  output logic [CNT_W-1:0]            remaining,
  output logic [NUM_PHASES-1:0]       expired,
  output logic                        err
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [CNT_W-1:0] dur [2**PHASE_W];
  logic [PHASE_W-1:0] nxt;
  logic legal;
  // Pad the table to a power of two so every phase index selects a defined entry.
  for (genvar i = 0; i < 2**PHASE_W; i++) begin : g_dur
    if (i < NUM_PHASES) begin : g_used
      assign dur[i] = dur_vec[i*CNT_W +: CNT_W];
    end else begin : g_pad
      assign dur[i] = '0;
    end
  end
  assign nxt = (32'(cur_phase) == NUM_PHASES - 1) ? '0 : cur_phase + PHASE_W'(1);
  assign legal = 32'(phase_sel) < NUM_PHASES;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      cur_phase <= '0;
      remaining <= '0;
      expired   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      // Issued after this clear, an expiry flag set in the same cycle overrides it.
      if (clr_flags) expired <= '0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            if (!legal) begin
              err <= 1'b1;
            end else begin
              remaining <= dur[phase_sel];
              cur_phase <= phase_sel;
              busy      <= 1'b1;
              state     <= pause ? PAUSE : RUN;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (pause) begin
            state <= PAUSE;
          end else if (remaining != '0) begin
            remaining <= remaining - CNT_W'(1);
          end else begin
            done               <= 1'b1;
            expired[cur_phase] <= 1'b1;
            if (AUTO_CYCLE) begin
              cur_phase <= nxt;
              remaining <= dur[nxt];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
